// File: rtl/axilite_slave_pkg.sv
`default_nettype none
// ============================================================================
// axilite_slave_pkg: response codes, read-FSM encodings and LFSR step helper.
// Revision 1.0
// ============================================================================
package axilite_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci step for taps 8,6,5,4 (bit 7 is tap 8), shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axilite_slave_mem.sv
`default_nettype none
// ============================================================================
// axilite_slave_mem: 1R1W synchronous RAM, registered read, read-before-write.
// Revision 1.0
// ============================================================================
module axilite_slave_mem #(
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [MEM_DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [MEM_DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-index read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/axilite_slave_model.sv
`default_nettype none
// ============================================================================
// axilite_slave_model: AXI-lite slave with write-pattern checker and counters.
// Revision 1.0 -- optional ready backpressure: AXILITE_SLAVE_BACKPRESSURE_EN
// ============================================================================
module axilite_slave_model
  import axilite_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 64,
  parameter int          DATA_WIDTH     = 64,
  parameter int          MEM_DEPTH_LOG2 = 8,
  parameter logic [63:0] ADDR_BASE      = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           wr_count,
  output logic [31:0]           err_count,
  output logic                  err_flag
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);

  logic                  aw_held, w_held, aw_held_nxt, w_held_nxt;
  logic                  aw_rdy_q, w_rdy_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  aw_fire, w_fire, commit;
  logic [ADDR_WIDTH-1:0] wr_offset, exp_addr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  wr_in_range, mismatch;

  logic [0:0]            rstate;
  logic                  ar_fire, rd_ok;
  logic [ADDR_WIDTH-1:0] rd_offset;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // ---------------------------------------------------------------- write path
  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign commit  = aw_held && w_held && (!s_axi_bvalid || s_axi_bready);

  assign wr_offset   = aw_addr_q - BASE;
  assign wr_in_range = (aw_addr_q >= BASE) && ((wr_offset >> MEM_DEPTH_LOG2) == '0);
  assign exp_addr    = BASE + ADDR_WIDTH'(wr_count);
  assign exp_data    = DATA_WIDTH'(wr_count);
  assign mismatch    = (aw_addr_q != exp_addr) || (w_data_q != exp_data);

  always_comb begin
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    if (commit) begin
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
    end else begin
      if (aw_fire) aw_held_nxt = 1'b1;
      if (w_fire)  w_held_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) aw_addr_q <= s_axi_awaddr;
    if (w_fire)  w_data_q  <= s_axi_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_rdy_q     <= 1'b1;
      w_rdy_q      <= 1'b1;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      wr_count     <= '0;
      err_count    <= '0;
      err_flag     <= 1'b0;
    end else begin
      aw_held  <= aw_held_nxt;
      w_held   <= w_held_nxt;
      aw_rdy_q <= !aw_held_nxt;
      w_rdy_q  <= !w_held_nxt;
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        wr_count     <= wr_count + 32'd1;
        if (mismatch) begin
          if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
          err_flag <= 1'b1;
        end
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

`ifdef AXILITE_SLAVE_BACKPRESSURE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  // Pseudo-random stall layered on top of the hold-state ready.
  assign s_axi_awready = aw_rdy_q && !lfsr[0];
  assign s_axi_wready  = w_rdy_q && !lfsr[0];
`else
  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = w_rdy_q;
`endif

  // ----------------------------------------------------------------- read path
  assign s_axi_arready = (rstate == R_IDLE);
  assign s_axi_rvalid  = (rstate == R_RESP);
  assign ar_fire       = s_axi_arvalid && s_axi_arready;
  assign rd_offset     = s_axi_araddr - BASE;
  assign rd_in_range   = (s_axi_araddr >= BASE) && ((rd_offset >> MEM_DEPTH_LOG2) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= R_IDLE;
      rd_ok  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (s_axi_arvalid) begin
          rstate <= R_RESP;
          rd_ok  <= rd_in_range;
        end
        R_RESP: if (s_axi_rready) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // RAM output is not reset, so rdata is masked until a valid in-range beat.
  assign s_axi_rdata = (s_axi_rvalid && rd_ok) ? mem_rdata : '0;
  assign s_axi_rresp = (s_axi_rvalid && !rd_ok) ? RESP_SLVERR : RESP_OKAY;

  axilite_slave_mem #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (commit && wr_in_range),
    .wr_addr (wr_offset[MEM_DEPTH_LOG2-1:0]),
    .wr_data (w_data_q),
    .rd_en   (ar_fire),
    .rd_addr (rd_offset[MEM_DEPTH_LOG2-1:0]),
    .rd_data (mem_rdata)
  );

endmodule
`default_nettype wire

// File: doc/axilite_slave_model.md
Name: axilite_slave_model

Overview:
AXI-lite slave that sits directly downstream of the AXI-lite master test generator and terminates its write and read channels.
- Accepts independent AW/W beats, stores data in a small synchronous memory, returns B responses and serves AR/R reads.
- Checks the write stream against the generator's pattern: address = ADDR_BASE+n, data = n for the n-th write.
- Exposes write and error counters for the bench.

Parameters:
ADDR_WIDTH, 64, AW/AR address width
DATA_WIDTH, 64, W/R data width
MEM_DEPTH_LOG2, 8, log2 of memory entries (word-indexed)
ADDR_BASE, 64'h80000000, address of entry 0 and of the first expected write

Ports:
clk  in  1  clock
rst  in  1  reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
wr_count  out  32  committed writes
err_count  out  32  pattern mismatches
err_flag  out  1  sticky mismatch flag

Behaviour:
Reset (already decided):
- rst is synchronous, active-high; clock is clk.
- On reset: all valids 0; resp fields 2'b00; rdata 0; counters 0; err_flag 0; holding registers empty; read FSM in R_IDLE.
- Memory contents are not reset.
- Reset mid-transaction drops any in-flight beat without a response.

Write path:
- One-entry AW hold register and one-entry W hold register.
- awready = !aw_held; wready = !w_held, each registered from hold state.
- A beat is captured on valid&&ready; AW and W may arrive in either order or in the same cycle.
- Commit condition: aw_held && w_held && (!bvalid || bready).
- On commit cycle:
  - Index = (awaddr - ADDR_BASE)[MEM_DEPTH_LOG2-1:0].
  - In range (ADDR_BASE <= awaddr < ADDR_BASE+2^MEM_DEPTH_LOG2): memory written, bresp = 2'b00 (OKAY).
  - Out of range: no write, bresp = 2'b10 (SLVERR).
  - Both holds clear; bvalid = 1 the next cycle, held until bready.
- Minimum latency: AW+W accepted in cycle t, commit in t+1, bvalid in t+2.
- Back-to-back commits are allowed while bready stays high.

Pattern check on each commit:
- Compare awaddr against ADDR_BASE + wr_count (zero-extended) and wdata against wr_count (zero-extended).
- Either mismatch: err_count += 1 (saturates at 32'hFFFFFFFF); err_flag set sticky.
- wr_count += 1 on every commit, in or out of range; wraps at 2^32.

Read path (FSM R_IDLE, R_RESP):
- R_IDLE:
  - arready = 1.
  - On arvalid: sample address, issue memory read, go to R_RESP.
- R_RESP:
  - arready = 0; rvalid = 1 starting the cycle after AR accept.
  - rdata = memory word, rresp = OKAY; out of range gives rdata 0, rresp SLVERR.
  - Hold until rready, then return to R_IDLE. The next AR can be accepted in the cycle after the R handshake.
- Read and commit to the same index in the same cycle: the read returns the old data (read-before-write).

Optional Feature:
Macro AXILITE_SLAVE_BACKPRESSURE_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle.
  - When lfsr[0]==1, awready and wready are forced 0 that cycle, in addition to the normal hold gating.
  - B and R channels are unaffected.
- Undefined: no LFSR logic; ready depends only on hold state.

Decomposition:
- Package axilite_slave_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Read FSM state encodings R_IDLE, R_RESP.
  - LFSR_SEED = 8'hA5.
- One sub-module: axilite_slave_mem.
  - Parameterised 1R1W synchronous RAM: DATA_WIDTH wide, 2^MEM_DEPTH_LOG2 deep, registered read, read-before-write on collision.

Test Plan:
1. 16 writes addr 80000000+i, data i, AW/W in the same cycle, bready=1 -> 16 OKAY B beats; wr_count=16; err_count=0; read of 80000005 returns 5.
2. W beat leads AW by 3 cycles for write 0 -> wready low after capture; a single commit; bvalid 2 cycles after AW accept; no error.
3. Write addr 80000002, data 7 as the first write -> bresp OKAY; err_count=1; err_flag=1 and still 1 after 10 clean writes.
4. Write to 80000000+256 -> bresp SLVERR; memory unchanged; read of the same address gives rdata 0, rresp SLVERR.
5. bready low for 5 cycles with a second AW/W pending -> no second commit until B handshake; awready/wready stay low; no beat lost.
6. rst pulsed while rvalid=1 and rready=0 -> next cycle rvalid=0, arready=1, counters 0; with AXILITE_SLAVE_BACKPRESSURE_EN, 100 writes complete with err_count=0.
